// File: rtl/gpio_irq_port.sv
// Memory-mapped GPIO port with atomic PORT updates, alternate-function pad select,
// input synchroniser and rise/fall edge flags feeding a registered interrupt line.
module gpio_irq_port #(
    parameter int unsigned   WIDTH       = 32,
    parameter int unsigned   AW          = 32,
    parameter logic [AW-1:0] BASE_ADDR   = 'h80,
    parameter int unsigned   SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    output logic             hit,
    input  logic [WIDTH-1:0] alt_out,
    output logic [WIDTH-1:0] pin_sync,
    output logic             irq,
    inout  wire  [WIDTH-1:0] ioport
);

    typedef enum logic [3:0] {
        REG_DDR   = 4'd0,
        REG_PORT  = 4'd1,
        REG_PIN   = 4'd2,
        REG_PSET  = 4'd3,
        REG_PCLR  = 4'd4,
        REG_PTGL  = 4'd5,
        REG_AFSEL = 4'd6,
        REG_RISE  = 4'd7,
        REG_FALL  = 4'd8,
        REG_IFR   = 4'd9
    } reg_e;

    logic [AW-1:0]    offset;
    reg_e             sel;
    logic             wr;

    logic [WIDTH-1:0] ddr_q;
    logic [WIDTH-1:0] port_q;
    logic [WIDTH-1:0] afsel_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] ifr_q;
    logic [WIDTH-1:0] pin_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] pin;

    logic [WIDTH-1:0] port_next;
    logic [WIDTH-1:0] ifr_set;
    logic [WIDTH-1:0] ifr_clr;
    logic [WIDTH-1:0] rise_ev;
    logic [WIDTH-1:0] fall_ev;

    // Unsigned subtraction lets one compare cover both window bounds.
    assign offset = addr - BASE_ADDR;
    assign hit    = (offset < AW'(10));
    assign sel    = reg_e'(offset[3:0]);
    assign wr     = we & hit;

    assign pin      = sync_q[SYNC_STAGES-1];
    assign pin_sync = pin;

    assign rise_ev = pin & ~pin_d;
    assign fall_ev = ~pin & pin_d;
    assign ifr_set = (rise_ev & rise_q) | (fall_ev & fall_q);
    assign ifr_clr = (wr && sel == REG_IFR) ? wd : '0;

    always_comb begin
        port_next = port_q;
        if (wr) begin
            case (sel)
                REG_PORT: port_next = wd;
                REG_PSET: port_next = port_q | wd;
                REG_PCLR: port_next = port_q & ~wd;
                REG_PTGL: port_next = port_q ^ wd;
                default:  port_next = port_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ddr_q   <= '0;
            port_q  <= '0;
            afsel_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            ifr_q   <= '0;
            pin_d   <= '0;
            irq     <= 1'b0;
        end else begin
            port_q <= port_next;
            if (wr && sel == REG_DDR)   ddr_q   <= wd;
            if (wr && sel == REG_AFSEL) afsel_q <= wd;
            if (wr && sel == REG_RISE)  rise_q  <= wd;
            if (wr && sel == REG_FALL)  fall_q  <= wd;
            // New edge on a bit being cleared in the same cycle keeps the flag set.
            ifr_q <= (ifr_q & ~ifr_clr) | ifr_set;
            pin_d <= pin;
            irq   <= |ifr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= ioport;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        rd = '0;
        if (hit) begin
            case (sel)
                REG_DDR:   rd = ddr_q;
                REG_PORT:  rd = port_q;
                REG_PIN:   rd = pin;
                REG_AFSEL: rd = afsel_q;
                REG_RISE:  rd = rise_q;
                REG_FALL:  rd = fall_q;
                REG_IFR:   rd = ifr_q;
                default:   rd = '0;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign ioport[i] = ddr_q[i] ? (afsel_q[i] ? alt_out[i] : port_q[i]) : 1'bz;
    end

endmodule

// File: tb/tb_gpio_irq_port.sv
// Directed bench for gpio_irq_port (8 pins, 16-bit address, base 0x80).
// Pads carry pullups, so an undriven pad reads 1 and a driven-low pad reads 0.
module tb_gpio_irq_port;

    localparam int unsigned    WIDTH = 8;
    localparam int unsigned    AW    = 16;
    localparam logic [AW-1:0]  BASE  = 16'h0080;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             we  = 1'b0;
    logic [AW-1:0]    addr = '0;
    logic [WIDTH-1:0] wd = '0;
    logic [WIDTH-1:0] rd;
    logic             hit;
    logic [WIDTH-1:0] alt_out = '0;
    logic [WIDTH-1:0] pin_sync;
    logic             irq;
    wire  [WIDTH-1:0] ioport;

    logic [WIDTH-1:0] tb_en  = '0;
    logic [WIDTH-1:0] tb_val = '0;

    int checks = 0;
    int errors = 0;

    gpio_irq_port #(
        .WIDTH(WIDTH),
        .AW(AW),
        .BASE_ADDR(BASE),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .addr(addr),
        .wd(wd),
        .rd(rd),
        .hit(hit),
        .alt_out(alt_out),
        .pin_sync(pin_sync),
        .irq(irq),
        .ioport(ioport)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_tbpad
        pullup pu (ioport[i]);
        assign ioport[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write takes effect at the next posedge, returns at the following negedge.
    task automatic write_addr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic write_reg(input logic [3:0] off, input logic [WIDTH-1:0] d);
        write_addr(BASE + AW'(off), d);
    endtask

    task automatic read_chk(input string tag, input logic [3:0] off, input logic [WIDTH-1:0] exp);
        addr = BASE + AW'(off);
        we   = 1'b0;
        #1;
        check(tag, 32'(rd), 32'(exp));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for two cycles with nothing driving the pads
        @(negedge clk);
        #1;
        check("rst_pin_sync", 32'(pin_sync), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_ioport_z", 32'(ioport), 32'hFF);
        step(1);
        for (int i = 0; i < 10; i++) begin
            read_chk($sformatf("rst_reg%0d", i), 4'(i), 8'h00);
        end
        rst = 1'b0;

        // Pads pulled high since reset: no flag, and enabling RISE later sees no edge
        step(4);
        read_chk("pin_pulled_high", 4'd2, 8'hFF);
        read_chk("ifr_no_flag_high", 4'd9, 8'h00);
        write_reg(4'd7, 8'hFF);
        step(3);
        read_chk("ifr_level_no_flag", 4'd9, 8'h00);
        check("irq_level_no_flag", 32'(irq), 32'h0);
        write_reg(4'd7, 8'h00);

        // Address window decoding
        addr = BASE + 16'd10;
        #1;
        check("hit_above", 32'(hit), 32'h0);
        check("rd_above", 32'(rd), 32'h0);
        addr = BASE - 16'd1;
        #1;
        check("hit_below", 32'(hit), 32'h0);
        addr = BASE + 16'd9;
        #1;
        check("hit_top", 32'(hit), 32'h1);
        write_addr(BASE + 16'h0010, 8'hFF);
        write_addr(BASE + 16'd10, 8'hFF);
        read_chk("miss_write_ddr", 4'd0, 8'h00);

        // Atomic set/clear/toggle: 0x0F |0x30 &~0x03 ^0x81 = 0xBD
        write_reg(4'd1, 8'h0F);
        write_reg(4'd0, 8'hFF);
        write_reg(4'd3, 8'h30);
        write_reg(4'd4, 8'h03);
        write_reg(4'd5, 8'h81);
        read_chk("port_atomic", 4'd1, 8'hBD);
        check("ioport_atomic", 32'(ioport), 32'hBD);
        read_chk("pset_reads0", 4'd3, 8'h00);
        write_reg(4'd2, 8'h00);
        step(2);
        read_chk("pin_readback", 4'd2, 8'hBD);
        read_chk("ifr_masked_outputs", 4'd9, 8'h00);

        // Hand the pads to the bench, all low
        write_reg(4'd0, 8'h00);
        tb_val = 8'h00;
        tb_en  = 8'hFF;
        step(4);

        // Rise on bit 0: PIN after 2 edges, IFR after 3, irq after 4
        write_reg(4'd7, 8'h01);
        tb_val = 8'h01;
        step(2);
        read_chk("rise_pin", 4'd2, 8'h01);
        read_chk("rise_ifr_early", 4'd9, 8'h00);
        check("rise_irq_early", 32'(irq), 32'h0);
        step(1);
        read_chk("rise_ifr", 4'd9, 8'h01);
        check("rise_irq_lag", 32'(irq), 32'h0);
        step(1);
        check("rise_irq", 32'(irq), 32'h1);
        write_reg(4'd9, 8'h01);
        read_chk("ifr_w1c", 4'd9, 8'h00);
        check("irq_hold_after_clear", 32'(irq), 32'h1);
        step(1);
        check("irq_drop", 32'(irq), 32'h0);

        // Fall on bit 2 with FALL disabled, then rise with RISE enabled
        tb_val = 8'h05;
        step(4);
        write_reg(4'd7, 8'h04);
        tb_val = 8'h01;
        step(4);
        read_chk("fall_masked_ifr", 4'd9, 8'h00);
        check("fall_masked_irq", 32'(irq), 32'h0);
        tb_val = 8'h05;
        step(3);
        read_chk("rise2_ifr", 4'd9, 8'h04);
        step(1);
        check("rise2_irq", 32'(irq), 32'h1);
        write_reg(4'd9, 8'h04);
        step(1);
        read_chk("rise2_cleared", 4'd9, 8'h00);
        check("rise2_irq_drop", 32'(irq), 32'h0);

        // Clear racing a new rise on the same bit: set wins
        write_reg(4'd7, 8'h01);
        tb_val = 8'h04;
        step(3);
        tb_val = 8'h05;
        step(3);
        read_chk("race_pending", 4'd9, 8'h01);
        tb_val = 8'h04;
        step(2);
        tb_val = 8'h05;
        step(2);
        write_reg(4'd9, 8'h01);
        read_chk("race_set_wins", 4'd9, 8'h01);
        write_reg(4'd9, 8'h01);
        read_chk("race_then_clear", 4'd9, 8'h00);

        // Alternate function on bit 1, which also raises an edge flag through readback
        write_reg(4'd6, 8'h02);
        write_reg(4'd1, 8'h00);
        write_reg(4'd0, 8'h02);
        tb_en = 8'hFD;
        step(3);
        write_reg(4'd7, 8'h02);
        #1;
        check("alt_low", 32'(ioport[1]), 32'h0);
        alt_out = 8'h02;
        #1;
        check("alt_high", 32'(ioport[1]), 32'h1);
        alt_out = 8'h00;
        #1;
        check("alt_low_again", 32'(ioport[1]), 32'h0);
        @(negedge clk);
        alt_out = 8'h02;
        step(3);
        read_chk("alt_ifr", 4'd9, 8'h02);
        step(1);
        check("alt_irq", 32'(irq), 32'h1);

        // Reset mid-toggle
        alt_out = 8'h00;
        rst = 1'b1;
        step(1);
        #1;
        check("rst_mid_pad_z", 32'(ioport[1]), 32'h1);
        check("rst_mid_irq", 32'(irq), 32'h0);
        check("rst_mid_pin_sync", 32'(pin_sync), 32'h0);
        read_chk("rst_mid_ifr", 4'd9, 8'h00);
        read_chk("rst_mid_ddr", 4'd0, 8'h00);
        rst = 1'b0;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
